// File: rtl/dev_mem_responder_if.sv
// dev_mem_responder_if: device-memory bus between the MMU (master) and the responder (slave)
interface dev_mem_responder_if;
  logic [31:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        is_write;
  modport master (output addr, data_out, is_write, input data_in);
  modport slave (input addr, data_out, is_write, output data_in);
endinterface

// File: rtl/dev_mem_responder.sv
// dev_mem_responder: device-memory target routing to async SRAM and UART registers.
// Define BUS_ERR_CNT_EN to add an unmapped-write counter at UART_BASE+8.
module dev_mem_responder #(
  parameter int          SRAM_AW   = 21,
  parameter logic [31:0] UART_BASE = 32'h1FD003F8,
  parameter int          TXF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  dev_mem_responder_if.slave dev_mem,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [31:0]        sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [7:0]         uart_tx_data,
  output logic               uart_tx_valid,
  input  logic               uart_tx_ready,
  input  logic [7:0]         uart_rx_data,
  input  logic               uart_rx_valid
);
  localparam logic [1:0] IDLE = 2'd0, W_PULSE = 2'd1, W_HOLD = 2'd2;
  localparam int PW = $clog2(TXF_DEPTH);
  logic [1:0]         state;
  logic [SRAM_AW-1:0] w_addr;
  logic [31:0]        w_data, cnt_rd;
  logic [7:0]         txf [TXF_DEPTH];
  logic [PW:0]        wp, rp;
  logic [7:0]         rx_byte;
  logic tx_full, tx_overflow, rx_full, rx_overrun;
  logic is_sram, is_data, is_stat, busy, wr, push, pop, rd_clr;
  assign wr      = dev_mem.is_write;
  assign is_sram = ~|dev_mem.addr[31:SRAM_AW+2];
  assign is_data = dev_mem.addr == UART_BASE;
  assign is_stat = dev_mem.addr == UART_BASE + 32'd4;
  assign busy    = state != IDLE;
  assign rd_clr  = !wr && is_data;
  assign sram_ce_n = !rst;
  assign sram_be_n = 4'b0000;
  assign sram_we_n = state != W_PULSE;
  assign sram_oe_n = busy || !is_sram;
  assign sram_addr = busy ? w_addr : dev_mem.addr[SRAM_AW+1:2];
  assign sram_dq   = busy ? w_data : 32'bz;
  // SRAM reads during a pending write see the latched write data
  assign dev_mem.data_in = is_sram ? (busy ? w_data : sram_dq) :
                           is_data ? {24'b0, rx_byte} :
                           is_stat ? {28'b0, rx_overrun, tx_overflow, rx_full, ~tx_full} : cnt_rd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      w_addr <= '0;
      w_data <= '0;
    end else begin
      state <= state == W_PULSE ? W_HOLD : (wr && is_sram) ? W_PULSE : IDLE;
      if (wr && is_sram && state != W_PULSE) begin
        w_addr <= dev_mem.addr[SRAM_AW+1:2];
        w_data <= dev_mem.data_out;
      end
    end
  assign tx_full       = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign uart_tx_valid = wp != rp;
  assign uart_tx_data  = txf[rp[PW-1:0]];
  assign pop  = uart_tx_valid && uart_tx_ready;
  assign push = wr && is_data && (!tx_full || pop);
  always_ff @(posedge clk)
    if (push) txf[wp[PW-1:0]] <= dev_mem.data_out[7:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp          <= '0;
      rp          <= '0;
      tx_overflow <= 1'b0;
      rx_full     <= 1'b0;
      rx_overrun  <= 1'b0;
      rx_byte     <= 8'h0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      tx_overflow <= (tx_overflow && !(wr && is_stat && dev_mem.data_out[2])) ||
                     (wr && is_data && tx_full && !pop);
      rx_overrun  <= (rx_overrun && !(wr && is_stat && dev_mem.data_out[3])) ||
                     (uart_rx_valid && rx_full && !rd_clr);
      rx_full     <= uart_rx_valid || (rx_full && !rd_clr);
      if (uart_rx_valid && (!rx_full || rd_clr)) rx_byte <= uart_rx_data;
    end
`ifdef BUS_ERR_CNT_EN
  logic [15:0] cnt;
  logic is_cnt;
  assign is_cnt = dev_mem.addr == UART_BASE + 32'd8;
  assign cnt_rd = is_cnt ? {16'b0, cnt} : 32'h0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (wr && is_cnt) cnt <= '0;
    else if (wr && !(is_sram || is_data || is_stat) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
`else
  assign cnt_rd = 32'h0;
`endif
endmodule

// File: tb/tb_dev_mem_responder.sv
// tb_dev_mem_responder: directed scoreboard bench with an SRAM model and TX byte monitor
module tb_dev_mem_responder;
  localparam logic [31:0] UB = 32'h1FD003F8;
  localparam logic [31:0] IDLE_A = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] sram_addr;
  wire  [31:0] sram_dq;
  logic sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0] sram_be_n;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic uart_tx_valid, uart_tx_ready, uart_rx_valid;
  logic [31:0] mem_model [0:1023] = '{default: 32'h0};
  logic [63:0] sram_q [$];
  logic [7:0]  tx_q [$];
  logic [63:0] e_sram;
  logic [7:0]  e_tx;
  int passed = 0;
  int total = 0;
  dev_mem_responder_if bus ();
  dev_mem_responder #(.SRAM_AW(16), .UART_BASE(UB), .TXF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .dev_mem(bus.slave),
    .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid)
  );
  always #5 clk = ~clk;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem_model[sram_addr[9:0]] : 32'bz;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.addr = a; bus.data_out = d; bus.is_write = 1'b1;
    @(posedge clk); #1;
    bus.is_write = 1'b0; bus.addr = IDLE_A;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    bus.addr = a; bus.is_write = 1'b0;
    #2 check(tag, bus.data_in, exp);
  endtask
  task automatic rx_pulse(input logic [7:0] b);
    @(posedge clk); #1;
    uart_rx_data = b; uart_rx_valid = 1'b1;
    @(posedge clk); #1;
    uart_rx_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst && !sram_we_n) begin
      check("sram_pulse_expected", 32'(sram_q.size() != 0), 32'd1);
      if (sram_q.size() != 0) begin
        e_sram = sram_q.pop_front();
        check("sram_wr_addr", 32'(sram_addr), e_sram[63:32]);
        check("sram_wr_data", sram_dq, e_sram[31:0]);
        mem_model[sram_addr[9:0]] = sram_dq;
      end
    end
    if (rst && uart_tx_valid && uart_tx_ready) begin
      check("tx_pop_expected", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) begin
        e_tx = tx_q.pop_front();
        check("tx_byte", 32'(uart_tx_data), 32'(e_tx));
      end
    end
  end
  initial begin
    bus.addr = UB + 32'd4; bus.data_out = 32'h0; bus.is_write = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_be_n", 32'(sram_be_n), 32'd0);
    check("rst_tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rst_status", bus.data_in, 32'h1);
    bus.addr = IDLE_A;
    @(posedge clk); #1 rst = 1'b1;
    #1 check("run_ce_n", 32'(sram_ce_n), 32'd0);
    rd(IDLE_A, 32'h0, "unmapped_read");
    // single write then read back through forwarding and through the SRAM
    sram_q.push_back({32'd4, 32'hDEADBEEF});
    wr(32'h10, 32'hDEADBEEF);
    rd(32'h10, 32'hDEADBEEF, "fwd_single");
    check("oe_n_busy", 32'(sram_oe_n), 32'd1);
    repeat (2) @(posedge clk);
    rd(32'h10, 32'hDEADBEEF, "sram_read_10");
    check("oe_n_read", 32'(sram_oe_n), 32'd0);
    // back-to-back writes two cycles apart
    sram_q.push_back({32'd0, 32'h11112222});
    sram_q.push_back({32'd1, 32'h33334444});
    wr(32'h0, 32'h11112222);
    wr(32'h4, 32'h33334444);
    rd(32'h8, 32'h33334444, "fwd_hold");
    repeat (2) @(posedge clk);
    rd(32'h0, 32'h11112222, "sram_read_0");
    rd(32'h4, 32'h33334444, "sram_read_4");
    rd(32'h8, 32'h0, "sram_read_8");
    check("sram_q_empty", 32'(sram_q.size()), 32'd0);
    // TX overflow with transmitter stalled
    for (int i = 0; i < 5; i++) begin
      if (i < 4) tx_q.push_back(8'h41 + 8'(i));
      wr(UB, 32'h41 + 32'(i));
    end
    rd(UB + 32'd4, 32'h4, "status_tx_ovf");
    check("tx_head", 32'(uart_tx_data), 32'h41);
    wr(UB + 32'd4, 32'h4);
    rd(UB + 32'd4, 32'h0, "status_ovf_clr");
    // RX overrun
    rx_pulse(8'h55);
    rx_pulse(8'h66);
    rd(UB + 32'd4, 32'hA, "status_rx_ovr");
    rd(UB, 32'h55, "rx_data");
    rd(UB + 32'd4, 32'h8, "status_rx_clr");
    wr(UB + 32'd4, 32'h8);
    rd(UB + 32'd4, 32'h0, "status_ovr_clr");
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("tx_drain_1", 32'(tx_q.size()), 32'd0);
    check("tx_valid_empty", 32'(uart_tx_valid), 32'd0);
    rd(UB + 32'd4, 32'h1, "status_tx_empty");
    // push and pop together while full: push must succeed
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'h61 + 8'(i));
      wr(UB, 32'h61 + 32'(i));
    end
    tx_q.push_back(8'h65);
    @(posedge clk); #1;
    bus.addr = UB; bus.data_out = 32'h65; bus.is_write = 1'b1; uart_tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.is_write = 1'b0; bus.addr = IDLE_A;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("tx_drain_2", 32'(tx_q.size()), 32'd0);
    rd(UB + 32'd4, 32'h1, "status_no_ovf");
    // reset in the middle of a write pulse
    rx_pulse(8'h77);
    rx_pulse(8'h88);
    rd(UB + 32'd4, 32'hB, "status_pre_rst");
    wr(32'h20, 32'hCAFEF00D);
    check("we_n_pulse", 32'(sram_we_n), 32'd0);
    #1 rst = 1'b0; bus.addr = 32'h20;
    #1;
    check("rst_we_n_async", 32'(sram_we_n), 32'd1);
    check("rst_dq_released", bus.data_in, 32'h0);
    @(posedge clk); #1 rst = 1'b1; bus.addr = IDLE_A;
    rd(UB + 32'd4, 32'h1, "status_post_rst");
    rd(32'h20, 32'h0, "aborted_write");
    // unmapped writes and the optional error counter
    for (int i = 0; i < 3; i++) wr(32'h00F00000, 32'h12345678);
    rd(32'h00F00000, 32'h0, "unmapped_high");
`ifdef BUS_ERR_CNT_EN
    rd(UB + 32'd8, 32'h3, "err_cnt");
    wr(UB + 32'd8, 32'h0);
    rd(UB + 32'd8, 32'h0, "err_cnt_clr");
`else
    rd(UB + 32'd8, 32'h0, "err_cnt_absent");
`endif
    check("sram_q_final", 32'(sram_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dev_mem_responder.md
Name: dev_mem_responder

Overview:
- Target side of the device-memory bus driven by the MMU. Decodes `dev_mem_addr` (word-aligned, bits [31:29]=0) and routes accesses to the external asynchronous SRAM or the UART register pair.
- Returns read data on `dev_mem_data_in` combinationally in the same cycle.
- Turns each one-cycle `dev_mem_is_write` into a timed SRAM write or a UART TX FIFO push. Buffers UART RX in a one-byte holding register.

Parameters:
- SRAM_AW, 21, SRAM word-address width; SRAM region is byte addresses 0 .. 4*2^SRAM_AW-1.
- UART_BASE, 32'h1FD003F8, byte address of the UART data register; the status register is at UART_BASE+4.
- TXF_DEPTH, 4, TX FIFO depth in bytes; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset.
- dev_mem_addr  in  32  word-aligned byte address from the initiator.
- dev_mem_data_out  in  32  write data from the initiator.
- dev_mem_is_write  in  1  write strobe; high for exactly one clock per write.
- dev_mem_data_in  out  32  read data to the initiator.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_dq  inout  32  SRAM data bus.
- sram_ce_n  out  1  SRAM chip enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_be_n  out  4  SRAM byte enables, active low.
- uart_tx_data  out  8  byte to the transmitter.
- uart_tx_valid  out  1  TX FIFO non-empty.
- uart_tx_ready  in  1  transmitter accepts `uart_tx_data` this cycle.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  one-cycle pulse: `uart_rx_data` is valid.

Behaviour:

Reset:
- Reset rst, asynchronous, active-low.
- On reset: write FSM to IDLE, `sram_we_n`=1, `sram_dq` released (Z), TX FIFO empty, `uart_tx_valid`=0, RX holding empty, sticky bits cleared.
- Reset mid-write aborts the write immediately; `sram_we_n` returns to 1 asynchronously.

Decode (combinational):
- SRAM region: `dev_mem_addr[31:2]` < 2^SRAM_AW.
- UART data register: `addr` == UART_BASE.
- UART status register: `addr` == UART_BASE+4.
- Anything else is unmapped.

Static SRAM outputs:
- `sram_ce_n`=0 while not in reset.
- `sram_be_n`=4'b0000 at all times; the initiator performs read-modify-write for sub-word writes.

Reads (combinational, no side effects except RX clear):
- SRAM region: `sram_addr` = `addr[SRAM_AW+1:2]`, `sram_oe_n`=0, `dev_mem_data_in` = `sram_dq`.
- UART data register: `{24'b0, rx_byte}`.
- UART status register: `{28'b0, rx_overrun, tx_overflow, rx_full, ~tx_full}`.
- Unmapped: 32'h0.

SRAM write FSM, states IDLE / W_PULSE / W_HOLD:
- IDLE: on posedge with `is_write`=1 and SRAM region, latch addr and data, go to W_PULSE.
- W_PULSE: `sram_we_n`=0, `sram_oe_n`=1, `sram_addr` = latched address, `sram_dq` driven with latched data. Always go to W_HOLD.
- W_HOLD: `sram_we_n`=1, `sram_dq` still driven, `sram_oe_n`=1.
  - A new SRAM write in this cycle is latched and the FSM goes to W_PULSE (back-to-back writes 2 cycles apart are supported).
  - Otherwise go to IDLE.
- While in W_PULSE or W_HOLD, an SRAM-region read returns the latched write data (forwarding), whatever its address.

UART TX:
- On posedge with `is_write`=1 and address = data register: push `data_out[7:0]`.
- If the FIFO is full, drop the byte and set `tx_overflow` (sticky).
- A push and a pop in the same cycle when full: the pop frees a slot first, so the push succeeds.
- `uart_tx_data` = FIFO head. Pop on posedge when `uart_tx_valid` and `uart_tx_ready` are both 1.

UART RX:
- On `uart_rx_valid` with the holding register empty: load the byte, `rx_full`=1.
- On `uart_rx_valid` with the holding register full: drop the byte, set `rx_overrun` (sticky).
- The holding register clears on posedge with addr = data register and `is_write`=0. A simultaneous new byte is loaded instead (no overrun).

Status writes and unmapped writes:
- Write 1 to status bit 2 or bit 3 clears that sticky bit.
- Unmapped writes are ignored.

Optional Feature:
- Macro BUS_ERR_CNT_EN.
- Defined: a 16-bit saturating counter increments on each posedge with `is_write`=1 to an unmapped address. It is readable at UART_BASE+8 as `{16'b0, cnt}` and cleared by any write to UART_BASE+8.
- Not defined: no counter; UART_BASE+8 is unmapped and reads 0.

Test Plan:
- Write 32'hDEADBEEF to 0x00000010, then read 0x00000010 -> `sram_we_n` low for exactly 1 cycle with `sram_addr`=4; read returns DEADBEEF.
- Writes to 0x0 and 0x4 two cycles apart -> two W_PULSEs with correct addr/data; a read of 0x8 during W_HOLD returns the forwarded data.
- `uart_tx_ready`=0, 5 writes of 0x41..0x45 to UART_BASE -> FIFO holds 41..44, status reads 0x4; after ready goes high, output order is 41,42,43,44.
- `uart_rx_valid` pulses with 0x55 then 0x66 before any read -> data register reads 0x55, status 0xA; a read of UART_BASE clears `rx_full`.
- Assert rst during W_PULSE -> `sram_we_n`=1 and `sram_dq`=Z immediately; status reads 0x1 after release.
- With BUS_ERR_CNT_EN defined, 3 writes to 0x00F00000 with SRAM_AW=16 -> UART_BASE+8 reads 3; without the macro it reads 0.
